// File: rtl/jojo_game_pkg.sv
// Shared types and defaults for the JoJo game-state controller.
package jojo_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } game_state_e;

  localparam int LIVES_INIT_DEF    = 3;
  localparam int INVULN_FRAMES_DEF = 90;
  localparam int SCORE_W_DEF       = 16;

  // Movers hold position whenever play is not actively running.
  function automatic logic is_frozen(game_state_e s);
    return (s == IDLE) || (s == PAUSE) || (s == OVER);
  endfunction

endpackage

// File: rtl/jojo_game_ctrl_rise_detect.sv
// Rising-edge detector for debounced button levels; one-clk pulse per 0->1 step.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/jojo_game_ctrl.sv
// Game-state controller: lives, survival score, post-hit invulnerability/blink,
// pause, and freeze/game-over outputs. All outputs are registered.
module jojo_game_ctrl
  import jojo_game_pkg::*;
#(
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int LIVES_W       = 3,
  parameter int INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int INVULN_W      = 8,
  parameter int BLINK_SHIFT   = 3,
  parameter int SCORE_W       = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               collision,
  input  logic               start_btn,
  input  logic               pause_btn,
  output game_state_e        state,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               jojo_visible,
  output logic               freeze,
  output logic               hit_pulse,
  output logic               game_over
);

  localparam logic [LIVES_W-1:0]  LIVES_RELOAD = LIVES_W'(LIVES_INIT);
  localparam logic [INVULN_W-1:0] INVULN_LOAD  = INVULN_W'(INVULN_FRAMES);

  logic                start_rise, pause_rise;
  game_state_e         state_n, ret_q, ret_n;
  logic [LIVES_W-1:0]  lives_n;
  logic [SCORE_W-1:0]  score_n, score_inc;
  logic [INVULN_W-1:0] cnt_q, cnt_n;
  logic                hit_n;

  rise_detect u_start_rise (.clk(clk), .rst(rst), .level(start_btn), .pulse(start_rise));
  rise_detect u_pause_rise (.clk(clk), .rst(rst), .level(pause_btn), .pulse(pause_rise));

  assign score_inc = (score == '1) ? score : score + SCORE_W'(1);

  always_comb begin
    state_n = state;
    ret_n   = ret_q;
    lives_n = lives;
    score_n = score;
    cnt_n   = cnt_q;
    hit_n   = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_n = PLAY;
          lives_n = LIVES_RELOAD;
          score_n = '0;
        end
      end
      PLAY: begin
        if (tick) score_n = score_inc;
        // A collision consumes any pause edge arriving in the same cycle.
        if (collision) begin
          hit_n   = 1'b1;
          lives_n = lives - LIVES_W'(1);
          if (lives == LIVES_W'(1)) begin
            state_n = OVER;
          end else begin
            state_n = HIT;
            cnt_n   = INVULN_LOAD;
          end
        end else if (pause_rise) begin
          state_n = PAUSE;
          ret_n   = PLAY;
        end
      end
      HIT: begin
        if (tick) score_n = score_inc;
        if (pause_rise) begin
          state_n = PAUSE;
          ret_n   = HIT;
        end else if (tick) begin
          cnt_n = cnt_q - INVULN_W'(1);
          if (cnt_q == INVULN_W'(1)) state_n = PLAY;
        end
      end
      PAUSE: begin
        if (pause_rise) state_n = ret_q;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ret_q        <= IDLE;
      lives        <= LIVES_RELOAD;
      score        <= '0;
      cnt_q        <= '0;
      jojo_visible <= 1'b1;
      freeze       <= 1'b1;
      hit_pulse    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      ret_q        <= ret_n;
      lives        <= lives_n;
      score        <= score_n;
      cnt_q        <= cnt_n;
      // Blink phase tracks the post-update counter so the flag is registered too.
      jojo_visible <= (state_n == HIT) ? ~cnt_n[BLINK_SHIFT] : 1'b1;
      freeze       <= is_frozen(state_n);
      hit_pulse    <= hit_n;
      game_over    <= (state_n == OVER);
    end
  end

endmodule
